// File: rtl/prio_arb_encoder.sv
// Registered priority arbiter: snapshots a request vector and drains it one
// grant per cycle over valid/ready, in fixed (MSB-first) or round-robin order.
module prio_arb_encoder #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot,
   output logic         busy
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t       state;
   logic [N-1:0] snap;
   logic         mode_q;
   logic [W-1:0] ptr;

   logic [W-1:0]   fix_idx;
   logic [W-1:0]   rr_off;
   logic [W:0]     rr_sum;
   logic [W-1:0]   rr_idx;
   logic [W-1:0]   sel_idx;
   logic [W-1:0]   ptr_next;
   logic [2*N-1:0] dbl_shift;
   logic [N-1:0]   rot;
   logic           xfer;

   // Highest set bit wins: the last assignment in an ascending scan.
   always_comb begin
      fix_idx = '0;
      for (int j = 0; j < N; j++) begin
         if (snap[j]) fix_idx = W'(j);
      end
   end

   // Rotate snap so that bit 0 of rot is snap[ptr]; the lowest set bit of rot
   // is then the first request at or above ptr with wrap-around.
   always_comb begin
      dbl_shift = {snap, snap} >> ptr;
      rot       = dbl_shift[N-1:0];
      rr_off    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) rr_off = W'(k);
      end
      rr_sum = {1'b0, ptr} + {1'b0, rr_off};
      if (rr_sum >= (W+1)'(N)) rr_sum = rr_sum - (W+1)'(N);
      rr_idx = rr_sum[W-1:0];
   end

   assign sel_idx  = mode_q ? rr_idx : fix_idx;
   assign ptr_next = (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);

   assign busy      = (state == BUSY);
   assign out_valid = busy;
   assign out_idx   = busy ? sel_idx : '0;
   assign xfer      = busy && out_ready;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_onehot
         assign out_onehot[gi] = busy && (sel_idx == W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         snap   <= '0;
         mode_q <= 1'b0;
         ptr    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req != '0) begin
                  snap   <= req;
                  mode_q <= mode;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (xfer) begin
                  snap <= snap & ~out_onehot;
                  if (mode_q) ptr <= ptr_next;
                  if ((snap & ~out_onehot) == '0) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prio_arb_encoder.sv
// Directed bench for prio_arb_encoder: vector table plus hand-written
// backpressure, reset, idle and N=5 wrap sequences.
module tb_prio_arb_encoder;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       mode;
   logic       out_ready;
   logic       out_valid;
   logic [2:0] out_idx;
   logic [7:0] out_onehot;
   logic       busy;

   logic [4:0] req5;
   logic       mode5;
   logic       out_ready5;
   logic       out_valid5;
   logic [2:0] out_idx5;
   logic [4:0] out_onehot5;
   logic       busy5;

   int n_chk;
   int n_fail;

   prio_arb_encoder #(.N(8)) dut (
      .clk(clk), .rst(rst), .req(req), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_onehot(out_onehot), .busy(busy)
   );

   prio_arb_encoder #(.N(5)) dut5 (
      .clk(clk), .rst(rst), .req(req5), .mode(mode5),
      .out_valid(out_valid5), .out_ready(out_ready5), .out_idx(out_idx5),
      .out_onehot(out_onehot5), .busy(busy5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] req;
      logic       mode;
      logic       rdy;
      logic       v;
      logic [2:0] idx;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Drive inputs, let one rising edge pass, settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string name, input logic v, input logic [2:0] idx);
      logic [7:0] oh;
      oh = v ? (8'b1 << idx) : 8'b0;
      chk({name, "_valid"}, 32'(out_valid), 32'(v));
      chk({name, "_busy"}, 32'(busy), 32'(v));
      chk({name, "_idx"}, 32'(out_idx), v ? 32'(idx) : 32'd0);
      chk({name, "_onehot"}, 32'(out_onehot), 32'(oh));
   endtask

   task automatic chk5(input string name, input logic v, input logic [2:0] idx);
      logic [4:0] oh;
      oh = v ? (5'b1 << idx) : 5'b0;
      chk({name, "_valid"}, 32'(out_valid5), 32'(v));
      chk({name, "_idx"}, 32'(out_idx5), v ? 32'(idx) : 32'd0);
      chk({name, "_onehot"}, 32'(out_onehot5), 32'(oh));
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;

      // Each row: inputs held across one edge, outputs expected after it.
      tbl[0] = '{8'hA4, 1'b0, 1'b1, 1'b1, 3'd7};
      tbl[1] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd5};
      tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd2};
      tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 3'd0};  // req ignored on final transfer: bubble
      tbl[4] = '{8'h24, 1'b1, 1'b1, 1'b1, 3'd2};
      tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 3'd5};
      tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0};
      tbl[7] = '{8'h41, 1'b1, 1'b1, 1'b1, 3'd6};
      tbl[8] = '{8'h00, 1'b1, 1'b1, 1'b1, 3'd0};
      tbl[9] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0};

      rst = 1'b1; req = '0; mode = 1'b0; out_ready = 1'b0;
      req5 = '0; mode5 = 1'b0; out_ready5 = 1'b1;
      step();
      chk8("reset", 1'b0, 3'd0);
      chk("reset_ptr", 32'(dut.ptr), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         req = tbl[i].req; mode = tbl[i].mode; out_ready = tbl[i].rdy;
         step();
         chk8($sformatf("row%0d", i), tbl[i].v, tbl[i].idx);
         if (i == 3) chk("fixed_ptr", 32'(dut.ptr), 32'd0);
         if (i == 6) chk("rr_ptr_a", 32'(dut.ptr), 32'd6);
         if (i == 9) chk("rr_ptr_b", 32'(dut.ptr), 32'd1);
      end

      // Backpressure: stall on index 5 while req/mode churn.
      req = 8'h24; mode = 1'b0; out_ready = 1'b0;
      step();
      chk8("bp_first", 1'b1, 3'd5);
      for (int c = 0; c < 3; c++) begin
         req = 8'hFF; mode = c[0] ? 1'b0 : 1'b1;
         step();
         chk8($sformatf("bp_hold%0d", c), 1'b1, 3'd5);
         chk($sformatf("bp_snap%0d", c), 32'(dut.snap), 32'h24);
      end
      out_ready = 1'b1;
      step();
      chk8("bp_next", 1'b1, 3'd2);
      step();
      chk8("bp_done", 1'b0, 3'd0);
      req = 8'h00;
      step();
      chk8("bp_idle", 1'b0, 3'd0);
      chk("bp_ptr", 32'(dut.ptr), 32'd1);

      // Reset mid-burst with two bits left.
      req = 8'h07; mode = 1'b1;
      step();
      req = 8'h00;
      chk8("mr_g0", 1'b1, 3'd1);
      step();
      chk8("mr_g1", 1'b1, 3'd2);
      #2 rst = 1'b1;
      #1;
      chk8("mr_async", 1'b0, 3'd0);
      chk("mr_ptr", 32'(dut.ptr), 32'd0);
      step();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk8($sformatf("mr_after%0d", c), 1'b0, 3'd0);
      end

      // Idle stability with a nonzero pointer.
      req = 8'h08; mode = 1'b1;
      step();
      req = 8'h00;
      chk8("id_grant", 1'b1, 3'd3);
      step();
      chk("id_ptr0", 32'(dut.ptr), 32'd4);
      for (int c = 0; c < 20; c++) begin
         step();
         chk8($sformatf("idle%0d", c), 1'b0, 3'd0);
         chk($sformatf("idle%0d_ptr", c), 32'(dut.ptr), 32'd4);
      end

      // N=5: steer ptr to 4, then wrap 4 -> 0.
      req5 = 5'b01000; mode5 = 1'b1;
      step();
      req5 = '0;
      chk5("n5_g3", 1'b1, 3'd3);
      step();
      chk5("n5_idle0", 1'b0, 3'd0);
      chk("n5_ptr4", 32'(dut5.ptr), 32'd4);
      req5 = 5'b10001;
      step();
      req5 = '0;
      chk5("n5_g4", 1'b1, 3'd4);
      step();
      chk5("n5_g0", 1'b1, 3'd0);
      step();
      chk5("n5_idle1", 1'b0, 3'd0);
      chk("n5_ptr1", 32'(dut5.ptr), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
